// File: rtl/fp_pkg.sv
// Shared binary32 field widths, special encodings and operand-pair classification
// for the floating-point datapath.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        NORMAL,
        ZERO,
        INF,
        NAN
    } spec_e;

    // Priority: NaN operand, Inf*0, Inf*x, 0*x. Exponent 0 counts as zero (subnormals flushed).
    function automatic spec_e classify(input logic [31:0] a, input logic [31:0] b);
        logic a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        spec_e code;
        a_max  = (a[FRAC_W +: EXP_W] == '1);
        b_max  = (b[FRAC_W +: EXP_W] == '1);
        a_nan  = a_max && (a[FRAC_W-1:0] != '0);
        b_nan  = b_max && (b[FRAC_W-1:0] != '0);
        a_inf  = a_max && (a[FRAC_W-1:0] == '0);
        b_inf  = b_max && (b[FRAC_W-1:0] == '0);
        a_zero = (a[FRAC_W +: EXP_W] == '0);
        b_zero = (b[FRAC_W +: EXP_W] == '0);
        if (a_nan || b_nan)
            code = NAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            code = NAN;
        else if (a_inf || b_inf)
            code = INF;
        else if (a_zero || b_zero)
            code = ZERO;
        else
            code = NORMAL;
        return code;
    endfunction

endpackage

// File: rtl/fp_mul_main_if.sv
// Operand/result bundle for the binary32 multiplier; master drives operands,
// slave returns product and flags.
interface fp_mul_main_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] m;
    logic                  overflow;
    logic                  underflow;

    modport master (output a, b, input m, overflow, underflow);
    modport slave  (input a, b, output m, overflow, underflow);
endinterface

// File: rtl/fp_mul_round_norm.sv
// Combinational normalize/round/pack with overflow/underflow detection.
// Rounding is round-to-nearest-even when FP_MUL_RNE_EN is defined, truncation otherwise.
module fp_mul_round_norm
    import fp_pkg::*;
(
    input  spec_e              spec,
    input  logic               sign,
    input  logic [47:0]        prod,
    input  logic signed [9:0]  exp_in,
    output logic [31:0]        m,
    output logic               overflow,
    output logic               underflow
);

    logic [23:0]       mant;
    logic [23:0]       mant_f;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_f;
    logic              unused_bits;
`ifdef FP_MUL_RNE_EN
    logic              guard, round, sticky, inc;
    logic [24:0]       mant_r;
`endif

    always_comb begin
        mant        = prod[46:23];
        exp_n       = exp_in;
        mant_f      = '0;
        exp_f       = '0;
        unused_bits = 1'b0;
`ifdef FP_MUL_RNE_EN
        guard       = prod[22];
        round       = prod[21];
        sticky      = |prod[20:0];
        inc         = 1'b0;
        mant_r      = '0;
`endif
        if (prod[47]) begin
            mant  = prod[47:24];
            exp_n = exp_in + 10'sd1;
`ifdef FP_MUL_RNE_EN
            guard  = prod[23];
            round  = prod[22];
            sticky = |prod[21:0];
`endif
        end
`ifdef FP_MUL_RNE_EN
        inc    = guard && (round || sticky || mant[0]);
        mant_r = {1'b0, mant} + {24'd0, inc};
        // Carry out of the rounder only happens from all-ones, so the result is 1.0 x 2^(e+1).
        if (mant_r[24]) begin
            mant_f = mant_r[24:1];
            exp_f  = exp_n + 10'sd1;
        end else begin
            mant_f = mant_r[23:0];
            exp_f  = exp_n;
        end
        unused_bits = mant_f[23];
`else
        mant_f      = mant;
        exp_f       = exp_n;
        unused_bits = mant_f[23] ^ (^prod[22:0]);
`endif
    end

    always_comb begin
        m         = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        case (spec)
            NAN:  m = QNAN;
            INF:  m = POS_INF | {sign, 31'd0};
            ZERO: m = {sign, 31'd0};
            default: begin
                if (exp_f >= 10'sd255) begin
                    m        = POS_INF | {sign, 31'd0};
                    overflow = 1'b1;
                end else if (exp_f <= 10'sd0) begin
                    m         = {sign, 31'd0};
                    underflow = 1'b1;
                end else begin
                    m = {sign, exp_f[7:0], mant_f[22:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_main.sv
// Two-stage pipelined binary32 multiplier, subnormals flushed to zero.
// Build option: FP_MUL_RNE_EN selects round-to-nearest-even instead of truncation.
module fp_mul_main
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fp_mul_main_if.slave bus
);

    logic [23:0]       mant_a, mant_b;
    logic signed [9:0] exp_sum;
    logic [47:0]       prod;
    spec_e             spec;

    spec_e             s1_spec;
    logic              s1_sign;
    logic [47:0]       s1_prod;
    logic signed [9:0] s1_exp;

    logic [31:0]       m_n;
    logic              overflow_n, underflow_n;

    always_comb begin
        mant_a  = {1'b1, bus.a[FRAC_W-1:0]};
        mant_b  = {1'b1, bus.b[FRAC_W-1:0]};
        exp_sum = $signed({2'b00, bus.a[FRAC_W +: EXP_W]})
                + $signed({2'b00, bus.b[FRAC_W +: EXP_W]})
                - 10'(BIAS);
        prod    = {24'd0, mant_a} * {24'd0, mant_b};
        spec    = classify(bus.a, bus.b);
    end

    // Stage 1 resets to a positive ZERO so stage 2 presents 0 with no flags after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_spec <= ZERO;
            s1_sign <= 1'b0;
            s1_prod <= '0;
            s1_exp  <= '0;
        end else begin
            s1_spec <= spec;
            s1_sign <= bus.a[31] ^ bus.b[31];
            s1_prod <= prod;
            s1_exp  <= exp_sum;
        end
    end

    fp_mul_round_norm u_round_norm (
        .spec      (s1_spec),
        .sign      (s1_sign),
        .prod      (s1_prod),
        .exp_in    (s1_exp),
        .m         (m_n),
        .overflow  (overflow_n),
        .underflow (underflow_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m         <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.m         <= m_n;
            bus.overflow  <= overflow_n;
            bus.underflow <= underflow_n;
        end
    end

endmodule

// File: tb/tb_fp_mul_main.sv
// Directed-vector bench for fp_mul_main: specials, normal products, range limits,
// rounding mode, back-to-back pipelining and mid-stream reset.
module tb_fp_mul_main;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fp_mul_main_if #(.DATA_WIDTH(32)) bus ();

    fp_mul_main dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef FP_MUL_RNE_EN
    localparam logic [31:0] RND_EXP = 32'h4010_0002;
`else
    localparam logic [31:0] RND_EXP = 32'h4010_0001;
`endif

    task automatic check(input string tag, input logic [31:0] em, input logic eo, input logic eu);
        checks++;
        assert (bus.m === em) else begin
            failures++;
            $error("FAIL %s m observed=%08h expected=%08h", tag, bus.m, em);
        end
        checks++;
        assert (bus.overflow === eo) else begin
            failures++;
            $error("FAIL %s overflow observed=%b expected=%b", tag, bus.overflow, eo);
        end
        checks++;
        assert (bus.underflow === eu) else begin
            failures++;
            $error("FAIL %s underflow observed=%b expected=%b", tag, bus.underflow, eu);
        end
    endtask

    // Drive at a falling edge; result is valid two rising edges later.
    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] em, input logic eo, input logic eu);
        @(negedge clk);
        bus.a = va;
        bus.b = vb;
        @(negedge clk);
        @(negedge clk);
        check(tag, em, eo, eu);
    endtask

    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [31:0] pm [4];
    logic        po [4];
    logic        pu [4];

    initial begin
        rst   = 1'b1;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        check("reset", 32'h0000_0000, 1'b0, 1'b0);
        rst = 1'b0;

        run_vec("zero_op",   32'h3C2F_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_vec("nan_op",    32'h4FF0_0800, 32'h7F90_0000, 32'h7FC0_0000, 1'b0, 1'b0);
        run_vec("neg_nan",   32'hFFC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
        run_vec("inf_x_0",   32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0);
        run_vec("inf_x_neg", 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b0, 1'b0);
        run_vec("negzero",   32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_vec("subnorm",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_vec("three",     32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        run_vec("no_shift",  32'h3FC0_0000, 32'h3FA0_0000, 32'h3FF0_0000, 1'b0, 1'b0);
        run_vec("ovf",       32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0);
        run_vec("ovf_neg",   32'hFF00_0000, 32'h7F00_0000, 32'hFF80_0000, 1'b1, 1'b0);
        run_vec("ovf_edge",  32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0);
        run_vec("big_ok",    32'h7F00_0000, 32'h3FC0_0000, 32'h7F40_0000, 1'b0, 1'b0);
        run_vec("unf",       32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1);
        run_vec("min_norm",  32'h2000_0000, 32'h2000_0000, 32'h0080_0000, 1'b0, 1'b0);
        run_vec("unf_edge",  32'h2000_0000, 32'h1F80_0000, 32'h0000_0000, 1'b0, 1'b1);
        run_vec("rounding",  32'h3FC0_0001, 32'h3FC0_0001, RND_EXP,       1'b0, 1'b0);

        pa[0] = 32'hC000_0000; pb[0] = 32'h4040_0000; pm[0] = 32'hC0C0_0000; po[0] = 1'b0; pu[0] = 1'b0;
        pa[1] = 32'h3FC0_0000; pb[1] = 32'h4000_0000; pm[1] = 32'h4040_0000; po[1] = 1'b0; pu[1] = 1'b0;
        pa[2] = 32'h7F00_0000; pb[2] = 32'h7F00_0000; pm[2] = 32'h7F80_0000; po[2] = 1'b1; pu[2] = 1'b0;
        pa[3] = 32'h0080_0000; pb[3] = 32'h0080_0000; pm[3] = 32'h0000_0000; po[3] = 1'b0; pu[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) check($sformatf("pipe%0d", i - 2), pm[i-2], po[i-2], pu[i-2]);
            if (i < 4) begin
                bus.a = pa[i];
                bus.b = pb[i];
            end
        end

        @(negedge clk);
        bus.a = 32'h7F00_0000;
        bus.b = 32'h7F00_0000;
        @(negedge clk);
        bus.a = 32'h3FC0_0000;
        bus.b = 32'h4000_0000;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", 32'h0000_0000, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_drain", 32'h0000_0000, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst", 32'h4040_0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
